// File: rtl/gray_counter_if.sv
// gray_counter_if: control inputs and count outputs of gray_counter
interface gray_counter_if #(parameter int NUM_PIN = 3);
  logic en, up, sat, load;
  logic [NUM_PIN:0] load_bin, bin, gray;
  logic wrap, at_max, at_min;
  modport master(output en, up, sat, load, load_bin, input bin, gray, wrap, at_max, at_min);
  modport slave(input en, up, sat, load, load_bin, output bin, gray, wrap, at_max, at_min);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down wrap/saturate counter with registered binary, gray and status outputs
module gray_counter #(
  parameter int NUM_PIN = 3,
  parameter int RESET_VAL = 0
) (
  input logic clk,
  input logic rst,
  gray_counter_if.slave bus
);
  localparam int W = NUM_PIN + 1;
  localparam logic [NUM_PIN:0] MAX = '1;
  localparam logic [NUM_PIN:0] RV = W'(RESET_VAL);
  logic [NUM_PIN:0] bin_q, gray_q, nxt;
  logic wrap_q, max_q, min_q, nwrap, at_top, at_bot;
  always_comb begin
    at_top = bin_q == MAX;
    at_bot = bin_q == '0;
    nxt = bus.load ? bus.load_bin :
          !bus.en ? bin_q :
          bus.up ? (at_top && bus.sat ? bin_q : bin_q + W'(1)) :
                   (at_bot && bus.sat ? bin_q : bin_q - W'(1));
    nwrap = !bus.load && bus.en && !bus.sat && (bus.up ? at_top : at_bot);
  end
  // gray and flags derive from the next binary value so they never lag bin
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin_q <= RV;
      gray_q <= RV ^ (RV >> 1);
      wrap_q <= 1'b0;
      max_q <= RV == MAX;
      min_q <= RV == '0;
    end else begin
      bin_q <= nxt;
      gray_q <= nxt ^ (nxt >> 1);
      wrap_q <= nwrap;
      max_q <= nxt == MAX;
      min_q <= nxt == '0;
    end
  assign bus.bin = bin_q;
  assign bus.gray = gray_q;
  assign bus.wrap = wrap_q;
  assign bus.at_max = max_q;
  assign bus.at_min = min_q;
endmodule
